// File: rtl/softmax_pkg.sv
// Shared types and width helpers for the softmax normalizer.
// Optional build macro honoured by this slice: SOFTMAX_ROUND_EN (round-half-up division).
package softmax_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index registers need at least one bit even for a single-element range.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    function automatic int exp_width(input int nnew);
        return nnew + 1;
    endfunction

    function automatic int sum_width(input int nnew, input int vec_len);
        return nnew + 1 + clog2(vec_len);
    endfunction

    localparam int N_DEF       = 16;
    localparam int NNEW_DEF    = N_DEF + 6;
    localparam int VEC_LEN_DEF = 8;
    localparam int EXPW        = exp_width(NNEW_DEF);
    localparam int SUMW        = sum_width(NNEW_DEF, VEC_LEN_DEF);

endpackage

// File: rtl/softmax_normalizer_seq_divider.sv
// Sequential restoring divider for fractions dividend/divisor (dividend <= divisor), one
// quotient bit per cycle after a load cycle. SOFTMAX_ROUND_EN adds one bit for round-half-up.
module seq_divider
    import softmax_pkg::*;
#(
    parameter int DW = 23,
    parameter int VW = 26,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

`ifdef SOFTMAX_ROUND_EN
    localparam int ITER = QW + 1;
`else
    localparam int ITER = QW;
`endif
    localparam int CW = idx_width(ITER);

    logic [VW-1:0]   rem;
    logic [VW-1:0]   dvs;
    logic [ITER-2:0] q;
    logic [CW-1:0]   cnt;
    logic            running;
    logic            zero_div;
    logic            sat;

    logic [VW:0]     rem_sh;
    logic            ge;
    logic [VW-1:0]   rem_nx;
    logic [ITER-1:0] q_nx;
    logic [QW-1:0]   rounded;
    logic [QW:0]     rsum;

    // The remainder never exceeds the divisor, so the shifted value fits in VW+1 bits.
    always_comb begin
        rem_sh = {rem, 1'b0};
        ge     = (rem_sh >= {1'b0, dvs});
        rem_nx = ge ? VW'(rem_sh - {1'b0, dvs}) : rem_sh[VW-1:0];
        q_nx   = {q, ge};
        rsum   = '0;
`ifdef SOFTMAX_ROUND_EN
        rsum    = {1'b0, q_nx[ITER-1:1]} + {{QW{1'b0}}, q_nx[0]};
        rounded = rsum[QW] ? '1 : rsum[QW-1:0];
`else
        rounded = q_nx;
`endif
        if (zero_div)  quotient = '0;
        else if (sat)  quotient = '1;
        else           quotient = rounded;
    end

    assign done = running && (cnt == CW'(ITER - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem      <= '0;
            dvs      <= '0;
            q        <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            zero_div <= 1'b0;
            sat      <= 1'b0;
        end else if (start) begin
            rem      <= VW'(dividend);
            dvs      <= divisor;
            q        <= '0;
            cnt      <= '0;
            running  <= 1'b1;
            zero_div <= (divisor == '0);
            sat      <= (VW'(dividend) == divisor);
        end else if (running) begin
            rem <= rem_nx;
            q   <= q_nx[ITER-2:0];
            cnt <= cnt + CW'(1);
            if (done) running <= 1'b0;
        end
    end

endmodule

// File: rtl/softmax_normalizer.sv
// Softmax normalizer: buffers VEC_LEN exponents (exp = x + y), sums them, then emits
// each exponent / sum as a Q0.N probability. SOFTMAX_ROUND_EN selects rounded division.
module softmax_normalizer
    import softmax_pkg::*;
#(
    parameter int N       = 16,
    parameter int NNEW    = N + 6,
    parameter int VEC_LEN = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NNEW-1:0] exp_x,
    input  logic [NNEW-1:0] exp_y,
    input  logic            exp_valid,
    output logic            in_ready,
    input  logic            out_ready,
    output logic [N-1:0]    prob_out,
    output logic            prob_valid,
    output logic            prob_last,
    output logic            busy,
    output state_t          state
);

    localparam int EW = exp_width(NNEW);
    localparam int SW = sum_width(NNEW, VEC_LEN);
    localparam int IW = idx_width(VEC_LEN);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready and prob_valid are registered and never depend on same-cycle inputs.
    logic [EW-1:0] buf_mem [VEC_LEN];
    logic [SW-1:0] sum;
    logic [IW-1:0] idx;
    logic [EW-1:0] exp_sum;
    logic          accept;
    logic          div_load;
    logic          div_done;
    logic [N-1:0]  div_result;
    logic          is_last_idx;

    assign exp_sum     = EW'(exp_x) + EW'(exp_y);
    assign accept      = exp_valid && in_ready;
    assign is_last_idx = (idx == IW'(VEC_LEN - 1));

    always_ff @(posedge clk) begin
        if (accept) buf_mem[idx] <= exp_sum;
    end

    seq_divider #(
        .DW (EW),
        .VW (SW),
        .QW (N)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_load),
        .dividend (buf_mem[idx]),
        .divisor  (sum),
        .done     (div_done),
        .quotient (div_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            sum        <= '0;
            in_ready   <= 1'b1;
            prob_out   <= '0;
            prob_valid <= 1'b0;
            prob_last  <= 1'b0;
            busy       <= 1'b0;
            div_load   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        sum  <= sum + SW'(exp_sum);
                        busy <= 1'b1;
                        if (is_last_idx) begin
                            idx      <= '0;
                            state    <= DIVIDE;
                            in_ready <= 1'b0;
                            div_load <= 1'b1;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= ACCUM;
                        end
                    end
                end
                DIVIDE: begin
                    div_load <= 1'b0;
                    if (div_done) begin
                        prob_out   <= div_result;
                        prob_valid <= 1'b1;
                        prob_last  <= is_last_idx;
                        state      <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        prob_valid <= 1'b0;
                        prob_last  <= 1'b0;
                        if (prob_last) begin
                            sum      <= '0;
                            idx      <= '0;
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            idx      <= idx + IW'(1);
                            state    <= DIVIDE;
                            div_load <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Self-checking bench for softmax_normalizer (N=16, VEC_LEN=4); expected probabilities come
// from directed constants or an arithmetic model of exp*2^N/sum. Honours SOFTMAX_ROUND_EN.
module tb_softmax_normalizer;
    import softmax_pkg::*;

    localparam int N       = 16;
    localparam int NNEW    = 22;
    localparam int VEC_LEN = 4;
`ifdef SOFTMAX_ROUND_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif
    localparam longint unsigned MAXP = (64'd1 << N) - 1;

    logic            clk;
    logic            reset;
    logic [NNEW-1:0] exp_x;
    logic [NNEW-1:0] exp_y;
    logic            exp_valid;
    logic            in_ready;
    logic            out_ready;
    logic [N-1:0]    prob_out;
    logic            prob_valid;
    logic            prob_last;
    logic            busy;
    state_t          state;

    int checks = 0;
    int errors = 0;
    logic [N:0] exp_q[$];

    softmax_normalizer #(
        .N       (N),
        .NNEW    (NNEW),
        .VEC_LEN (VEC_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .exp_x      (exp_x),
        .exp_y      (exp_y),
        .exp_valid  (exp_valid),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .prob_out   (prob_out),
        .prob_valid (prob_valid),
        .prob_last  (prob_last),
        .busy       (busy),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned ref_prob(input longint unsigned e, input longint unsigned s);
        longint unsigned q;
        if (s == 0) return 0;
`ifdef SOFTMAX_ROUND_EN
        q = ((e << (N + 1)) / s + 1) >> 1;
`else
        q = (e << N) / s;
`endif
        if (q > MAXP) q = MAXP;
        return q;
    endfunction

    task automatic model_vector(input int unsigned ev[VEC_LEN]);
        longint unsigned s;
        s = 0;
        for (int i = 0; i < VEC_LEN; i++) s += ev[i];
        for (int i = 0; i < VEC_LEN; i++)
            exp_q.push_back({(i == VEC_LEN - 1), N'(ref_prob(ev[i], s))});
    endtask

    task automatic push_const(input int unsigned p[VEC_LEN]);
        for (int i = 0; i < VEC_LEN; i++)
            exp_q.push_back({(i == VEC_LEN - 1), N'(p[i])});
    endtask

    task automatic send_vector(input int unsigned ev[VEC_LEN]);
        int unsigned x;
        for (int i = 0; i < VEC_LEN; i++) begin
            x = $urandom_range(ev[i], 0);
            exp_x = NNEW'(x);
            exp_y = NNEW'(ev[i] - x);
            exp_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_accum: got %b expected 1 (element %0d)", in_ready, i);
            end
            @(posedge clk); #1;
        end
        exp_valid = 1'b0;
        exp_x = '0;
        exp_y = '0;
    endtask

    task automatic recv_element(input int hold);
        logic [N:0]   e;
        logic [N-1:0] p;
        logic         last;
        int           cyc;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected >0");
            return;
        end
        e = exp_q.pop_front();
        p = e[N-1:0];
        last = e[N];
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL divide_flags: got in_ready=%b busy=%b expected 0/1", in_ready, busy);
        end
        cyc = 0;
        while (prob_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc, LAT);
        end
        checks++;
        if (prob_out !== p) begin
            errors++;
            $display("FAIL prob_out: got %h expected %h", prob_out, p);
        end
        checks++;
        if (prob_last !== last) begin
            errors++;
            $display("FAIL prob_last: got %b expected %b", prob_last, last);
        end
        for (int h = 0; h < hold; h++) begin
            if (h == 2) begin
                exp_x = NNEW'($urandom_range(4095, 1));
                exp_y = NNEW'($urandom_range(4095, 1));
                exp_valid = 1'b1;
            end
            @(posedge clk); #1;
            exp_valid = 1'b0;
            checks++;
            if (prob_valid !== 1'b1 || prob_out !== p || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: got valid=%b out=%h in_ready=%b expected 1/%h/0",
                         prob_valid, prob_out, in_ready, p);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (last) begin
            if (prob_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || state !== IDLE) begin
                errors++;
                $display("FAIL vector_end: got valid=%b in_ready=%b busy=%b state=%0d expected 0/1/0/0",
                         prob_valid, in_ready, busy, state);
            end
        end else if (prob_valid !== 1'b0 || state !== DIVIDE) begin
            errors++;
            $display("FAIL next_element: got valid=%b state=%0d expected 0/%0d", prob_valid, state, DIVIDE);
        end
    endtask

    task automatic drain(input int hold_idx);
        for (int i = 0; i < VEC_LEN; i++) recv_element((i == hold_idx) ? 5 : 0);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (prob_out !== '0 || prob_valid !== 1'b0 || prob_last !== 1'b0 || busy !== 1'b0 ||
            in_ready !== 1'b1 || state !== IDLE) begin
            errors++;
            $display("FAIL %s: got out=%h valid=%b last=%b busy=%b in_ready=%b state=%0d expected 0/0/0/0/1/0",
                     name, prob_out, prob_valid, prob_last, busy, in_ready, state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        exp_valid = 1'b0;
        out_ready = 1'b0;
        exp_x = '0;
        exp_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("after_release");
    endtask

    task automatic test_equal();
        int unsigned ev[VEC_LEN];
        int unsigned pv[VEC_LEN];
        ev = '{32'h1000, 32'h1000, 32'h1000, 32'h1000};
        pv = '{32'h4000, 32'h4000, 32'h4000, 32'h4000};
        push_const(pv);
        send_vector(ev);
        drain(-1);
    endtask

    task automatic test_mixed();
        int unsigned ev[VEC_LEN];
        int unsigned pv[VEC_LEN];
        ev = '{32'h100, 32'h100, 32'h200, 32'h400};
        pv = '{32'h2000, 32'h2000, 32'h4000, 32'h8000};
        push_const(pv);
        send_vector(ev);
        drain(-1);
    endtask

    task automatic test_boundaries();
        int unsigned ev[VEC_LEN];
        int unsigned pv[VEC_LEN];
        ev = '{32'h500, 0, 0, 0};
        pv = '{32'hFFFF, 0, 0, 0};
        push_const(pv);
        send_vector(ev);
        drain(-1);
        ev = '{0, 0, 0, 0};
        pv = '{0, 0, 0, 0};
        push_const(pv);
        send_vector(ev);
        drain(-1);
    endtask

    task automatic test_rounding();
        int unsigned ev[VEC_LEN];
        int unsigned pv[VEC_LEN];
        ev = '{2, 1, 0, 0};
`ifdef SOFTMAX_ROUND_EN
        pv = '{32'hAAAB, 32'h5555, 0, 0};
`else
        pv = '{32'hAAAA, 32'h5555, 0, 0};
`endif
        push_const(pv);
        send_vector(ev);
        drain(-1);
    endtask

    task automatic test_backpressure();
        int unsigned ev[VEC_LEN];
        for (int i = 0; i < VEC_LEN; i++) ev[i] = $urandom_range(32'h3FFFFF, 1);
        model_vector(ev);
        send_vector(ev);
        drain(1);
    endtask

    task automatic test_reset_mid();
        int unsigned ev[VEC_LEN];
        int unsigned pv[VEC_LEN];
        for (int i = 0; i < VEC_LEN; i++) ev[i] = $urandom_range(1000, 200);
        model_vector(ev);
        send_vector(ev);
        recv_element(0);
        recv_element(0);
        exp_q.delete();
        repeat (5) @(posedge clk);
        #4;
        reset = 1'b0;
        #1;
        check_idle("async_reset");
        #20;
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("reset_recovered");
        ev = '{32'h1000, 32'h1000, 32'h1000, 32'h1000};
        pv = '{32'h4000, 32'h4000, 32'h4000, 32'h4000};
        push_const(pv);
        send_vector(ev);
        drain(-1);
    endtask

    task automatic test_back_to_back();
        int unsigned ev[VEC_LEN];
        int unsigned mode;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                mode = $urandom_range(3, 0);
                if (mode == 0)      ev[i] = 0;
                else if (mode == 1) ev[i] = $urandom_range(3, 1);
                else                ev[i] = $urandom_range(32'h3FFFFF, 0);
            end
            model_vector(ev);
            send_vector(ev);
            drain(-1);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_mixed();
        test_boundaries();
        test_rounding();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_normalizer.md
Name: softmax_normalizer

Overview:
- Downstream stage of the CORDIC exponent top.
- Accepts one exponent per strobe as the X/Y pair (exp = X + Y), buffers a vector of VEC_LEN exponents and accumulates their sum.
- Divides each buffered exponent by the sum with a sequential restoring divider.
- Emits softmax probabilities as unsigned Q0.N fractions over a valid/ready handshake.

Parameters:
- N, 16: probability width; equals the CORDIC angle width.
- NNEW, N+6: width of exp_x and exp_y (CORDIC X/Y width).
- VEC_LEN, 8: elements per softmax vector; must be ≥1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- exp_x  in  NNEW  CORDIC X output (cosh), unsigned.
- exp_y  in  NNEW  CORDIC Y output (sinh), unsigned.
- exp_valid  in  1  exponent strobe; driven from capture_div.
- in_ready  out  1  block accepts an exponent this cycle.
- out_ready  in  1  consumer accepts prob_out.
- prob_out  out  N  probability, Q0.N.
- prob_valid  out  1  prob_out is valid.
- prob_last  out  1  marks the final element of the vector.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Widths:
  - EXPW = NNEW+1; exp = exp_x + exp_y, zero-extended, no overflow.
  - SUMW = EXPW + clog2(VEC_LEN); the sum never wraps.
- Reset (reset=0): state IDLE, element index 0, sum 0, and every output 0 except in_ready. Buffer contents are don't-care. Reset asserted mid-operation aborts immediately; any partial vector is discarded.
- States: IDLE, ACCUM, DIVIDE, OUTPUT.
- IDLE and ACCUM:
  - in_ready = 1.
  - Each cycle with exp_valid & in_ready: buf[idx] <= exp, sum <= sum + exp, idx++. IDLE moves to ACCUM on the first accept.
  - On the VEC_LEN-th accept: idx <= 0, go to DIVIDE. The last element is added to the sum in that same cycle.
  - exp_valid while in_ready = 0 is ignored; no buffering and no error.
- DIVIDE, per element:
  - One load cycle, then N iteration cycles of restoring division of buf[idx] << N by sum, producing the N quotient bits MSB first.
  - Then go to OUTPUT. Latency from DIVIDE entry to prob_valid = N+1 cycles.
  - in_ready = 0.
- Boundary rules:
  - sum == 0: quotient forced to 0.
  - buf[idx] == sum: quotient would be 1.0, so it saturates to all-ones.
- OUTPUT:
  - prob_valid = 1. prob_out and prob_last stay stable until out_ready.
  - prob_last = 1 when idx == VEC_LEN-1.
  - On handshake: if last, clear sum and idx and go to IDLE (prob_valid falls next cycle); otherwise idx++ and go to DIVIDE.
- Simultaneous events: handshake and exp_valid in the same OUTPUT cycle drop the exp (in_ready = 0). In IDLE, the first accept is possible in the cycle after the final handshake.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SOFTMAX_ROUND_EN.
- Defined:
  - The divider runs N+1 iterations; the extra quotient bit is added as round-half-up.
  - A result that carries past all-ones saturates to all-ones.
  - Latency becomes N+2 cycles per element.
- Undefined: truncation, N iterations, latency N+1.

Decomposition:
- Package softmax_pkg:
  - state enum (IDLE/ACCUM/DIVIDE/OUTPUT).
  - localparams EXPW and SUMW.
  - clog2-based index width function.
- Sub-module seq_divider (restoring, parameterized dividend/divisor/quotient widths):
  - start/done handshake.
  - sum==0 and saturation handling live inside it.
  - The rounding macro is honoured inside it.
- Top: buffer, accumulator, FSM, output register.

Test Plan:
- Equal inputs: N=16, VEC_LEN=4; exp_x=0x1000, exp_y=0 on all four → prob_out = 0x4000 four times; prob_last on the 4th only.
- Mixed inputs: exps 0x100, 0x100, 0x200, 0x400 (split across x/y, e.g. x=0x300, y=0x100) → 0x2000, 0x2000, 0x4000, 0x8000.
- Saturation and zero sum:
  - 0x500, 0, 0, 0 → 0xFFFF, 0, 0, 0.
  - All-zero vector → four outputs of 0x0000; no hang.
- Rounding: exps 2, 1, 0, 0.
  - Without SOFTMAX_ROUND_EN → 0xAAAA, 0x5555, 0, 0.
  - With it → 0xAAAB, 0x5555, 0, 0.
  - Check latency of N+1 vs N+2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles on element 1 → prob_valid stays 1, prob_out stays stable, in_ready stays 0, and a pulsed exp_valid is dropped; release → sequence resumes correctly.
- Reset: assert reset=0 mid-DIVIDE of element 2 → outputs 0 and busy=0 asynchronously; after release, in_ready=1 and a fresh vector produces correct results with no stale sum.
